// File: rtl/maxpool_issuer_pkg.sv
// rtl/maxpool_issuer_pkg.sv - shared FSM encoding and FP16 constants for the max-pool issuer
package maxpool_issuer_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_NEG_INF = 16'hFC00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/maxpool_issuer_if.sv
// rtl/maxpool_issuer_if.sv - element stream, compare responder and pooled output bundle
interface maxpool_issuer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  logic [DW-1:0] cmp_new_data;
  logic [DW-1:0] cmp_ori_data;
  logic          cmp_data_ready;
  logic          cmp_data_valid;
  logic          cmp_pool_ready;
  logic          cmp_result;

  logic [DW-1:0] out_data;
  logic          out_valid;

  modport master (
    input  s_data, s_valid, cmp_data_valid, cmp_pool_ready, cmp_result,
    output s_ready, cmp_new_data, cmp_ori_data, cmp_data_ready, out_data, out_valid
  );

  modport slave (
    output s_data, s_valid, cmp_data_valid, cmp_pool_ready, cmp_result,
    input  s_ready, cmp_new_data, cmp_ori_data, cmp_data_ready, out_data, out_valid
  );
endinterface

// File: rtl/maxpool_issuer_pool_window_ctr.sv
// rtl/maxpool_issuer_pool_window_ctr.sv - element and window counters with terminal-count flags
module pool_window_ctr #(
  parameter int KERNEL_ELEMS = 9,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_clr,
  input  logic             win_inc,
  input  logic             elem_first,
  input  logic             elem_inc,
  input  logic [CNT_W-1:0] num_windows,
  output logic [CNT_W-1:0] win_idx,
  output logic             elem_last,
  output logic             win_last
);
  localparam logic [7:0] KERNEL_N = 8'(KERNEL_ELEMS);

  logic [7:0]       elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0] win_idx_q, win_idx_d;

  always_comb begin
    elem_cnt_d = elem_cnt_q;
    if (elem_first) begin
      elem_cnt_d = 8'd1;
    end else if (elem_inc) begin
      elem_cnt_d = elem_cnt_q + 8'd1;
    end
    win_idx_d = win_idx_q;
    if (win_clr) begin
      win_idx_d = '0;
    end else if (win_inc) begin
      win_idx_d = win_idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt_q <= 8'd0;
      win_idx_q  <= '0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      win_idx_q  <= win_idx_d;
    end
  end

  // Flags look one step ahead: the pending verdict / window completes the count.
  assign elem_last = (elem_cnt_q + 8'd1) == KERNEL_N;
  assign win_last  = (win_idx_q + CNT_W'(1)) == num_windows;
  assign win_idx   = win_idx_q;
endmodule

// File: rtl/maxpool_issuer.sv
// rtl/maxpool_issuer.sv - sequences pooling windows through the FP16 compare responder
module maxpool_issuer
  import maxpool_issuer_pkg::*;
#(
  parameter int KERNEL_ELEMS = 9,
  parameter int DW           = FP16_W,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_windows,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] win_idx,
  maxpool_issuer_if.master bus
);
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_ready_q, s_ready_d;
  logic             cmp_data_ready_q, cmp_data_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    cmp_new_q, cmp_new_d;
  logic [DW-1:0]    cmp_ori_q, cmp_ori_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [DW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] num_win_q, num_win_d;

  logic win_clr, elem_first, elem_inc, elem_last, win_last, s_hs;

  // The window index advances while the pooled value is presented, so out_data and win_idx agree.
  pool_window_ctr #(.KERNEL_ELEMS(KERNEL_ELEMS), .CNT_W(CNT_W)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .win_clr    (win_clr),
    .win_inc    (out_valid_q),
    .elem_first (elem_first),
    .elem_inc   (elem_inc),
    .num_windows(num_win_q),
    .win_idx    (win_idx),
    .elem_last  (elem_last),
    .win_last   (win_last)
  );

  assign s_hs = s_ready_q & bus.s_valid;

  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    cmp_data_ready_d = 1'b0;
    out_valid_d      = 1'b0;
    cmp_new_d        = cmp_new_q;
    cmp_ori_d        = cmp_ori_q;
    out_data_d       = out_data_q;
    max_d            = max_q;
    num_win_d        = num_win_q;
    win_clr          = 1'b0;
    elem_first       = 1'b0;
    elem_inc         = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        num_win_d = num_windows;
        busy_d    = 1'b1;
        win_clr   = 1'b1;
        state_d   = (num_windows == '0) ? ST_FIN : ST_FIRST;
      end
      ST_FIRST: if (s_hs) begin
        max_d      = bus.s_data;
        elem_first = 1'b1;
        state_d    = (KERNEL_ELEMS == 1) ? ST_EMIT : ST_FETCH;
      end
      ST_FETCH: if (s_hs) begin
        cmp_new_d = bus.s_data;
        cmp_ori_d = max_q;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: if (bus.cmp_data_valid) begin
        cmp_data_ready_d = 1'b1;
        state_d          = ST_WAIT;
      end
      ST_WAIT: if (bus.cmp_pool_ready) begin
        // Ties and NaN come back as 0, so the incumbent maximum wins.
        if (bus.cmp_result) max_d = cmp_new_q;
        elem_inc = 1'b1;
        state_d  = elem_last ? ST_EMIT : ST_FETCH;
      end
      ST_EMIT: begin
        out_data_d  = max_q;
        out_valid_d = 1'b1;
        state_d     = win_last ? ST_FIN : ST_FIRST;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready_d = (state_d == ST_FIRST) || (state_d == ST_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      s_ready_q        <= 1'b0;
      cmp_data_ready_q <= 1'b0;
      out_valid_q      <= 1'b0;
      cmp_new_q        <= FP16_ZERO;
      cmp_ori_q        <= FP16_ZERO;
      out_data_q       <= FP16_ZERO;
      max_q            <= FP16_ZERO;
      num_win_q        <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      s_ready_q        <= s_ready_d;
      cmp_data_ready_q <= cmp_data_ready_d;
      out_valid_q      <= out_valid_d;
      cmp_new_q        <= cmp_new_d;
      cmp_ori_q        <= cmp_ori_d;
      out_data_q       <= out_data_d;
      max_q            <= max_d;
      num_win_q        <= num_win_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.s_ready        = s_ready_q;
  assign bus.cmp_data_ready = cmp_data_ready_q;
  assign bus.cmp_new_data   = cmp_new_q;
  assign bus.cmp_ori_data   = cmp_ori_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
endmodule

// File: tb/tb_maxpool_issuer.sv
// tb/tb_maxpool_issuer.sv - directed bench with an FP16 max model and a 2-cycle responder
module tb_maxpool_issuer;
  import maxpool_issuer_pkg::*;

  localparam int K  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_windows = '0;
  logic          busy, done;
  logic [CW-1:0] win_idx;

  maxpool_issuer_if #(.DW(FP16_W)) bus ();

  maxpool_issuer #(.KERNEL_ELEMS(K), .DW(FP16_W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_windows(num_windows),
    .busy       (busy),
    .done       (done),
    .win_idx    (win_idx),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] win_tab [0:7][0:3];
  logic [15:0] feed_q [$];
  int  run_base = 0, run_w = 0, cur_w = 0, cur_s = 0;
  int  strobes = 0, outs = 0, dones = 0, sready_seen = 0, last_ov = 0, start_cyc = 0;
  int  hold_lo = 0, rsp_cnt = 0;
  bit  pend = 0, rand_valid = 0, drv_hs = 0;
  logic rsp_r = 1'b0, prev_cdv = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strict IEEE greater-than: NaN on either side and +0 vs -0 compare false.
  function automatic bit fp_gt(logic [15:0] a, logic [15:0] b);
    logic [15:0] ka, kb;
    if ((a[14:10] == 5'h1f && a[9:0] != 0) || (b[14:10] == 5'h1f && b[9:0] != 0)) return 1'b0;
    if (a[14:0] == 0 && b[14:0] == 0) return 1'b0;
    ka = a[15] ? ~a : (a | 16'h8000);
    kb = b[15] ? ~b : (b | 16'h8000);
    return ka > kb;
  endfunction

  function automatic logic [15:0] fmax(int w, int n);
    logic [15:0] m = win_tab[w][0];
    for (int i = 1; i < n; i++) if (fp_gt(win_tab[w][i], m)) m = win_tab[w][i];
    return m;
  endfunction

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(negedge clk);
      drv_hs = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (drv_hs && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && (!rand_valid || $urandom_range(0, 1) == 1)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = feed_q[0];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
      end
    end
  end

  initial begin
    bus.cmp_data_valid = 1'b0;
    bus.cmp_pool_ready = 1'b0;
    bus.cmp_result     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.cmp_pool_ready = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.cmp_pool_ready = 1'b1;
          bus.cmp_result     = rsp_r;
        end
      end
      if (bus.cmp_data_ready) begin
        rsp_cnt = 2;
        rsp_r   = fp_gt(bus.cmp_new_data, bus.cmp_ori_data);
      end
      if (hold_lo > 0) begin
        hold_lo--;
        bus.cmp_data_valid = 1'b0;
      end else begin
        bus.cmp_data_valid = (rsp_cnt == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.cmp_pool_ready) pend = 0;
    if (bus.s_ready) sready_seen++;
    if (bus.cmp_data_ready) begin
      strobes++;
      chk("cdv_before_strobe", 32'(prev_cdv), 1);
      chk("single_outstanding", 32'(pend), 0);
      pend = 1;
      if (cur_w < run_w && cur_s < K - 1) begin
        chk("cmp_new_data", bus.cmp_new_data, win_tab[run_base + cur_w][cur_s + 1]);
        chk("cmp_ori_data", bus.cmp_ori_data, fmax(run_base + cur_w, cur_s + 1));
      end else begin
        chk("strobe_expected", 0, 1);
      end
      cur_s++;
    end
    if (bus.out_valid) begin
      outs++;
      chk("out_valid_expected", 32'(cur_w < run_w), 1);
      if (cur_w < run_w) begin
        chk("out_data", bus.out_data, fmax(run_base + cur_w, K));
        chk("win_idx", win_idx, cur_w);
        chk("strobes_per_window", cur_s, K - 1);
      end
      cur_w++;
      cur_s   = 0;
      last_ov = cyc;
    end
    if (done) begin
      dones++;
      chk("busy_low_at_done", 32'(busy), 0);
      if (run_w == 0) chk("done_latency_empty", cyc - start_cyc, 2);
      else            chk("done_after_last_out", cyc - last_ov, 1);
    end
    prev_cdv = bus.cmp_data_valid;
  end

  task automatic begin_run(int base, int nw, bit rnd);
    @(negedge clk);
    #2;
    run_base = base; run_w = nw; cur_w = 0; cur_s = 0;
    strobes = 0; outs = 0; dones = 0; sready_seen = 0; rand_valid = rnd;
    for (int w = 0; w < nw; w++)
      for (int e = 0; e < K; e++) feed_q.push_back(win_tab[base + w][e]);
    num_windows = CW'(nw);
    start_cyc   = cyc;
    start       = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
  endtask

  task automatic do_run(int base, int nw, bit rnd, int hold, bit restart);
    begin_run(base, nw, rnd);
    if (restart) begin
      repeat (2) @(negedge clk);
      #2 num_windows = CW'(2);
      start = 1'b1;
      @(negedge clk);
      #2 start = 1'b0;
    end
    if (hold > 0) begin
      for (int i = 0; i < 200 && strobes == 0; i++) begin
        @(negedge clk);
        #2;
      end
      hold_lo = hold;
    end
    for (int i = 0; i < 2000 && dones == 0; i++) begin
      @(negedge clk);
      #2;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("done_count", dones, 1);
    chk("out_count", outs, nw);
    chk("strobes_total", strobes, nw * (K - 1));
    chk("feed_drained", feed_q.size(), 0);
    if (nw == 0) chk("no_s_ready_empty_run", sready_seen, 0);
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_cmp_data_ready"}, 32'(bus.cmp_data_ready), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_cmp_new_data"}, bus.cmp_new_data, 0);
    chk({tag, "_cmp_ori_data"}, bus.cmp_ori_data, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_win_idx"}, win_idx, 0);
  endtask

  initial begin
    win_tab[0] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200};
    win_tab[1] = '{16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    win_tab[2] = '{16'h4000, 16'h4000, 16'h7E00, 16'h3C00};
    win_tab[3] = '{16'hBC00, 16'hC000, 16'h3C00, 16'h0000};
    win_tab[4] = '{16'h7C00, 16'h4000, FP16_NEG_INF, 16'h4200};
    win_tab[5] = '{16'hC200, 16'hC400, 16'hC100, 16'hC300};
    win_tab[6] = '{16'h3555, 16'h3A00, 16'h3800, 16'h3900};
    win_tab[7] = '{16'h4500, 16'h4600, 16'h4700, 16'h4800};

    repeat (3) @(negedge clk);
    chk_cleared("reset");
    #2 rst = 1'b0;

    chk("model_w0", fmax(0, K), 16'h4200);
    chk("model_w1", fmax(1, K), 16'h4400);
    chk("model_w2_tie_nan", fmax(2, K), 16'h4000);
    chk("model_w3", fmax(3, K), 16'h3C00);
    chk("model_w4", fmax(4, K), 16'h7C00);
    chk("model_w5", fmax(5, K), 16'hC100);
    chk("model_w6", fmax(6, K), 16'h3A00);

    do_run(0, 1, 1'b0, 0, 1'b0);
    do_run(1, 1, 1'b0, 0, 1'b0);
    do_run(2, 1, 1'b0, 0, 1'b0);
    do_run(3, 3, 1'b1, 5, 1'b0);
    do_run(0, 0, 1'b0, 0, 1'b0);
    do_run(0, 1, 1'b0, 0, 1'b1);

    begin_run(7, 1, 1'b0);
    for (int i = 0; i < 200 && strobes == 0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("reset_test_strobe_seen", 32'(strobes > 0), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    chk_cleared("midrun_reset");
    run_w = 0; cur_w = 0; cur_s = 0;
    feed_q.delete();
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("no_out_after_reset", outs, 0);
    chk("no_done_after_reset", dones, 0);
    chk("idle_after_reset", 32'(busy), 0);
    chk("no_s_ready_after_reset", 32'(bus.s_ready), 0);

    do_run(6, 1, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/maxpool_issuer.md
Name: maxpool_issuer

Overview:
- Initiator side of the FP16 max-pooling compare interface. It sequences pooling windows and feeds each candidate element, together with the running maximum, to the compare responder.
- It consumes the responder's greater-than verdict, updates the running max, and emits one pooled value per window.
- Sits between the pooling input buffer (element stream) and the output writeback in the pooling datapath.

Parameters:
- KERNEL_ELEMS, 9, elements per pooling window (kernel_w*kernel_h); legal range 1..255.
- DW, 16, element width (IEEE half precision).
- CNT_W, 16, width of the window counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches num_windows and begins; ignored unless idle
- num_windows  in  CNT_W  windows to process; 0 = finish immediately
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last window is emitted
- s_data  in  DW  input element
- s_valid  in  1  s_data valid
- s_ready  out  1  element accepted on s_valid&s_ready
- cmp_new_data  out  DW  candidate element to responder
- cmp_ori_data  out  DW  current running max to responder
- cmp_data_ready  out  1  one-cycle issue strobe to responder
- cmp_data_valid  in  1  responder ready-for-data
- cmp_pool_ready  in  1  responder verdict valid (one-cycle)
- cmp_result  in  1  verdict: 1 = new > ori
- out_data  out  DW  pooled maximum
- out_valid  out  1  one-cycle pulse with out_data
- win_idx  out  CNT_W  index of the window being processed

Behaviour:
- Reset (sync, rst high at posedge) returns the block to IDLE and clears every output and register:
  - busy, done, s_ready, cmp_data_ready, out_valid = 0.
  - cmp_new_data, cmp_ori_data, out_data = 16'h0000.
  - win_idx = 0; element counter = 0.
  - Reset mid-operation aborts the window with no out_valid.
  - Verdicts arriving after reset are ignored; the responder is not reset by this block.
- FSM states: IDLE, FIRST, FETCH, ISSUE, WAIT, EMIT, FIN.
  - IDLE: on start, latch num_windows. If it is 0, go to FIN; else go to FIRST with busy=1 and win_idx=0.
  - FIRST: s_ready=1. On handshake, running max := s_data and elem_cnt := 1. If KERNEL_ELEMS==1, go to EMIT; else go to FETCH. No comparison is made for the first element.
  - FETCH: s_ready=1. On handshake, cmp_new_data := s_data and cmp_ori_data := max; go to ISSUE.
  - ISSUE: wait for cmp_data_valid==1, then assert cmp_data_ready for exactly one cycle and go to WAIT. Operands stay stable from ISSUE through the verdict.
  - WAIT: on cmp_pool_ready, if cmp_result=1 then max := cmp_new_data, else max is kept.
    - Ties, and NaN (comparator outputs 0), keep the old max.
    - elem_cnt += 1. If elem_cnt reaches KERNEL_ELEMS, go to EMIT; else go to FETCH.
    - cmp_pool_ready arriving while not in WAIT is ignored.
  - EMIT: out_data := max and out_valid=1 for one cycle. win_idx += 1. If win_idx+1 == num_windows, go to FIN; else go to FIRST.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timing and occupancy:
  - Exactly one compare is outstanding at a time (no pipelining across verdicts).
  - Per-window latency = KERNEL_ELEMS-1 compare round trips plus input stalls plus 1 EMIT cycle.
- Input and control rules:
  - s_ready is 0 in every state except FIRST/FETCH. Input stalls (s_valid low) simply hold the state.
  - start while busy is ignored.
  - win_idx wraps naturally at 2^CNT_W; the terminal compare is on equality with num_windows, so no overflow handling is needed.
- No arithmetic is performed on the data; only select/copy.

Decomposition:
- Shared package: FSM state encoding constants, FP16 width, FP16 zero/negative-infinity constants.
- One sub-module is natural: pool_window_ctr (element and window counters with terminal-count flags).
- The FSM and datapath stay in the top module.

Test Plan:
- KERNEL_ELEMS=4, num_windows=1, elements 3C00,4000,3800,4200, responder model with 2-cycle latency -> exactly 3 cmp_data_ready strobes, out_data=4200, one out_valid, done one cycle after EMIT.
- Descending window 4400,4200,4000,3C00 -> every verdict 0, out_data=4400; cmp_ori_data stays 4400 on all issues.
- Tie/NaN: window 4000,4000,7E00 (NaN),3C00 -> out_data=4000.
- num_windows=3, s_valid toggled randomly, responder cmp_data_valid held low for 5 cycles -> no strobe while it is low; 3 out_valid pulses with win_idx 0,1,2.
- num_windows=0 -> done pulses 2 cycles after start, with no s_ready and no out_valid; start pulsed again while busy in another run -> ignored.
- rst asserted in WAIT mid-window, with the verdict arriving one cycle later -> no out_valid, all outputs 0, FSM in IDLE; a subsequent start runs a clean window correctly.
